// File: rtl/banner_sequencer.sv
// banner_sequencer: animates the on-screen text banner (DRAW / P1WIN / P2WIN /
// READY). A show request latches the message and its centred left edge, then
// each frame tick walks the banner through slide-in, hold, blink and slide-out
// before a single-cycle done pulse. All outputs come straight from registers.
module banner_sequencer #(
  parameter int SCREEN_W      = 640,
  parameter int CHAR_PITCH    = 31,
  parameter int TARGET_Y      = 200,
  parameter int STEP          = 8,
  parameter int HOLD_FRAMES   = 60,
  parameter int BLINK_PERIOD  = 8,
  parameter int BLINK_TOGGLES = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       show_req,
  input  logic [1:0] msg_sel,
  input  logic       clear_req,
  output logic [1:0] msg_id,
  output logic [9:0] start_x,
  output logic [9:0] start_y,
  output logic       banner_en,
  output logic       busy,
  output logic       done
);

  // Sequence phases; the state is "where the banner is", not the outputs.
  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_SLIDE_IN  = 3'd1,
    S_HOLD      = 3'd2,
    S_BLINK     = 3'd3,
    S_SLIDE_OUT = 3'd4
  } state_t;

  // Constants pre-sized so every compare and add is width-exact.
  localparam logic [10:0] C_SCREEN_W   = 11'(SCREEN_W);
  localparam logic [10:0] C_LEN4_PX    = 11'(4 * CHAR_PITCH);
  localparam logic [10:0] C_LEN5_PX    = 11'(5 * CHAR_PITCH);
  localparam logic [10:0] C_TARGET_Y   = 11'(TARGET_Y);
  localparam logic [10:0] C_STEP11     = 11'(STEP);
  localparam logic [9:0]  C_STEP10     = 10'(STEP);
  localparam logic [15:0] C_HOLD_LAST  = 16'(HOLD_FRAMES - 1);
  localparam logic [15:0] C_BLINK_LAST = 16'(BLINK_PERIOD - 1);
  localparam logic [15:0] C_TOG_LAST   = 16'(BLINK_TOGGLES - 1);

  state_t      r_state, r_state_next;
  logic [1:0]  r_msg_id, r_msg_id_next;
  logic [9:0]  r_start_x, r_start_x_next;
  logic [9:0]  r_start_y, r_start_y_next;
  logic        r_banner_en, r_banner_en_next;
  logic        r_busy, r_busy_next;
  logic        r_done, r_done_next;
  logic [15:0] r_frame_cnt, r_frame_cnt_next;
  logic [15:0] r_toggle_cnt, r_toggle_cnt_next;

  logic [10:0] w_len_px;
  logic [10:0] w_x_diff;
  logic [9:0]  w_target_x;
  logic [10:0] w_y_sum;
  logic        w_y_reached;
  logic [9:0]  w_y_sat;

  // Centred left edge of the requested message; only captured on accept.
  always_comb begin
    w_len_px   = (msg_sel == 2'd0) ? C_LEN4_PX : C_LEN5_PX;
    w_x_diff   = C_SCREEN_W - w_len_px;
    w_target_x = w_x_diff[10:1];
  end

  // Saturating slide-in step; 11 bits so the sum cannot wrap before the clamp.
  always_comb begin
    w_y_sum     = {1'b0, r_start_y} + C_STEP11;
    w_y_reached = (w_y_sum >= C_TARGET_Y);
    w_y_sat     = w_y_reached ? C_TARGET_Y[9:0] : w_y_sum[9:0];
  end

  // Next-state and next-output logic for the banner animation.
  always_comb begin
    r_state_next      = r_state;
    r_msg_id_next     = r_msg_id;
    r_start_x_next    = r_start_x;
    r_start_y_next    = r_start_y;
    r_banner_en_next  = r_banner_en;
    r_busy_next       = r_busy;
    r_done_next       = 1'b0;
    r_frame_cnt_next  = r_frame_cnt;
    r_toggle_cnt_next = r_toggle_cnt;

    case (r_state)
      S_IDLE: begin
        // A coincident clear cancels the request; a coincident tick is not a step.
        if (show_req && !clear_req) begin
          r_state_next      = S_SLIDE_IN;
          r_msg_id_next     = msg_sel;
          r_start_x_next    = w_target_x;
          r_start_y_next    = 10'd0;
          r_banner_en_next  = 1'b1;
          r_busy_next       = 1'b1;
          r_frame_cnt_next  = 16'd0;
          r_toggle_cnt_next = 16'd0;
        end
      end

      S_SLIDE_IN: begin
        if (clear_req) begin
          r_state_next     = S_SLIDE_OUT;
          r_banner_en_next = 1'b1;
        end else if (frame_tick) begin
          r_start_y_next = w_y_sat;
          if (w_y_reached) begin
            r_state_next     = S_HOLD;
            r_frame_cnt_next = 16'd0;
          end
        end
      end

      S_HOLD: begin
        if (clear_req) begin
          r_state_next     = S_SLIDE_OUT;
          r_banner_en_next = 1'b1;
          r_frame_cnt_next = 16'd0;
        end else if (frame_tick) begin
          if (r_frame_cnt == C_HOLD_LAST) begin
            r_state_next      = S_BLINK;
            r_frame_cnt_next  = 16'd0;
            r_toggle_cnt_next = 16'd0;
          end else begin
            r_frame_cnt_next = r_frame_cnt + 16'd1;
          end
        end
      end

      S_BLINK: begin
        if (clear_req) begin
          r_state_next      = S_SLIDE_OUT;
          r_banner_en_next  = 1'b1;
          r_frame_cnt_next  = 16'd0;
          r_toggle_cnt_next = 16'd0;
        end else if (frame_tick) begin
          if (r_frame_cnt == C_BLINK_LAST) begin
            r_frame_cnt_next = 16'd0;
            r_banner_en_next = ~r_banner_en;
            // Even toggle count leaves the banner visible for the slide-out.
            if (r_toggle_cnt == C_TOG_LAST) begin
              r_state_next      = S_SLIDE_OUT;
              r_toggle_cnt_next = 16'd0;
            end else begin
              r_toggle_cnt_next = r_toggle_cnt + 16'd1;
            end
          end else begin
            r_frame_cnt_next = r_frame_cnt + 16'd1;
          end
        end
      end

      S_SLIDE_OUT: begin
        // clear_req has nothing left to shorten here, so it is ignored.
        if (frame_tick) begin
          if (r_start_y <= C_STEP10) begin
            r_state_next     = S_IDLE;
            r_start_y_next   = 10'd0;
            r_banner_en_next = 1'b0;
            r_busy_next      = 1'b0;
            r_done_next      = 1'b1;
          end else begin
            r_start_y_next = r_start_y - C_STEP10;
          end
        end
      end

      default: begin
        r_state_next = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any sequence without a done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_msg_id     <= 2'd0;
      r_start_x    <= 10'd0;
      r_start_y    <= 10'd0;
      r_banner_en  <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_frame_cnt  <= 16'd0;
      r_toggle_cnt <= 16'd0;
    end else begin
      r_state      <= r_state_next;
      r_msg_id     <= r_msg_id_next;
      r_start_x    <= r_start_x_next;
      r_start_y    <= r_start_y_next;
      r_banner_en  <= r_banner_en_next;
      r_busy       <= r_busy_next;
      r_done       <= r_done_next;
      r_frame_cnt  <= r_frame_cnt_next;
      r_toggle_cnt <= r_toggle_cnt_next;
    end
  end

  assign msg_id    = r_msg_id;
  assign start_x   = r_start_x;
  assign start_y   = r_start_y;
  assign banner_en = r_banner_en;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule
